// File: rtl/dds_wave_gen.sv
// Direct-digital-synthesis waveform generator: phase accumulator -> shape -> amplitude scale -> DAC.
// Define DDS_SYNC_PULSE_EN to add the sync_out trigger that marks the first sample of each phase cycle.

module dds_wave_gen #(
    parameter int                 PHASE_W = 32,
    parameter int                 DATA_W  = 8,
    parameter logic [PHASE_W-1:0] RST_FW  = 'h0040_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               phase_clr,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_fw,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic [1:0]         cfg_wave,
    input  logic [7:0]         cfg_duty,
    input  logic [7:0]         cfg_amp,
    output logic [DATA_W-1:0]  da_data,
    output logic               da_valid
`ifdef DDS_SYNC_PULSE_EN
   ,output logic               sync_out
`endif
);

    localparam logic [1:0] WAVE_TRI   = 2'd0;
    localparam logic [1:0] WAVE_SAWUP = 2'd1;
    localparam logic [1:0] WAVE_SAWDN = 2'd2;
    localparam logic [1:0] WAVE_SQR   = 2'd3;
    localparam logic [7:0] RST_DUTY   = 8'd128;
    localparam logic [7:0] RST_AMP    = 8'd255;

    function automatic logic [DATA_W-1:0] wave_raw(
        input logic [1:0]        wave,
        input logic [DATA_W:0]   t,
        input logic [DATA_W-1:0] s,
        input logic [7:0]        q,
        input logic [7:0]        duty
    );
        logic [DATA_W-1:0] res;
        res = '0;
        case (wave)
            WAVE_TRI:   res = t[DATA_W] ? ~t[DATA_W-1:0] : t[DATA_W-1:0];
            WAVE_SAWUP: res = s;
            WAVE_SAWDN: res = ~s;
            WAVE_SQR:   res = (q < duty) ? {DATA_W{1'b1}} : '0;
            default:    res = '0;
        endcase
        return res;
    endfunction

    // Scale by (amp+1)/256 with truncation; the DATA_W+9 product never overflows.
    function automatic logic [DATA_W-1:0] scale_amp(
        input logic [DATA_W-1:0] raw,
        input logic [7:0]        amp
    );
        logic [DATA_W+8:0] prod;
        prod = (DATA_W+9)'(raw) * (DATA_W+9)'({1'b0, amp} + 9'd1);
        return DATA_W'(prod >> 8);
    endfunction

    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_fw,    r_sh_fw;
    logic [PHASE_W-1:0] r_poff,  r_sh_poff, r_poff_p1;
    logic [1:0]         r_wave,  r_sh_wave, r_wave_p1;
    logic [7:0]         r_duty,  r_sh_duty, r_duty_p1;
    logic [7:0]         r_amp,   r_sh_amp,  r_amp_p1, r_amp_p2;
    logic               r_pending;
    logic               r_vld_p1, r_vld_p2;
    logic [DATA_W-1:0]  r_raw_p2;

    logic [PHASE_W:0]   w_sum;
    logic               w_carry;
    logic               w_accept;
    logic               w_commit;
    logic [PHASE_W-1:0] w_phase;
    logic [DATA_W:0]    w_t;
    logic [DATA_W-1:0]  w_s;
    logic [7:0]         w_q;

    assign w_sum     = {1'b0, r_acc} + {1'b0, r_fw};
    assign w_carry   = enable & ~phase_clr & w_sum[PHASE_W];
    assign w_accept  = cfg_valid & ~r_pending;
    assign w_commit  = r_pending & (w_carry | ~enable | phase_clr);
    assign cfg_ready = ~r_pending;

    // Stage 1: configuration handshake, commit at phase wrap, accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_acc     <= '0;
            r_fw      <= RST_FW;
            r_poff    <= '0;
            r_wave    <= WAVE_TRI;
            r_duty    <= RST_DUTY;
            r_amp     <= RST_AMP;
            r_sh_fw   <= RST_FW;
            r_sh_poff <= '0;
            r_sh_wave <= WAVE_TRI;
            r_sh_duty <= RST_DUTY;
            r_sh_amp  <= RST_AMP;
        end else begin
            if (w_accept) begin
                r_sh_fw   <= cfg_fw;
                r_sh_poff <= cfg_poff;
                r_sh_wave <= cfg_wave;
                r_sh_duty <= cfg_duty;
                r_sh_amp  <= cfg_amp;
            end
            if (w_commit) begin
                r_fw   <= r_sh_fw;
                r_poff <= r_sh_poff;
                r_wave <= r_sh_wave;
                r_duty <= r_sh_duty;
                r_amp  <= r_sh_amp;
            end
            if (w_accept)
                r_pending <= 1'b1;
            else if (w_commit)
                r_pending <= 1'b0;
            if (phase_clr)
                r_acc <= '0;
            else if (enable)
                r_acc <= w_sum[PHASE_W-1:0];
        end
    end

    // The shaping config travels with the acc value it belongs to, so a commit lands on one sample boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_poff_p1 <= '0;
            r_wave_p1 <= WAVE_TRI;
            r_duty_p1 <= RST_DUTY;
            r_amp_p1  <= RST_AMP;
            r_vld_p1  <= 1'b0;
        end else begin
            r_poff_p1 <= r_poff;
            r_wave_p1 <= r_wave;
            r_duty_p1 <= r_duty;
            r_amp_p1  <= r_amp;
            r_vld_p1  <= enable;
        end
    end

    // Stage 2: phase offset and waveform shaping
    assign w_phase = r_acc + r_poff_p1;
    assign w_t     = (DATA_W+1)'(w_phase >> (PHASE_W - DATA_W - 1));
    assign w_s     = DATA_W'(w_phase >> (PHASE_W - DATA_W));
    assign w_q     = 8'(w_phase >> (PHASE_W - 8));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw_p2 <= '0;
            r_amp_p2 <= RST_AMP;
            r_vld_p2 <= 1'b0;
        end else begin
            r_raw_p2 <= wave_raw(r_wave_p1, w_t, w_s, w_q, r_duty_p1);
            r_amp_p2 <= r_amp_p1;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // Stage 3: amplitude scaling into the DAC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            da_data  <= '0;
            da_valid <= 1'b0;
        end else begin
            da_data  <= scale_amp(r_raw_p2, r_amp_p2);
            da_valid <= r_vld_p2;
        end
    end

`ifdef DDS_SYNC_PULSE_EN
    logic r_sync_p1, r_sync_p2;

    // Marks the acc value registered on a wrap or clear, delayed to its sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_p1 <= 1'b0;
            r_sync_p2 <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            r_sync_p1 <= w_carry | phase_clr;
            r_sync_p2 <= r_sync_p1;
            sync_out  <= r_sync_p2;
        end
    end
`endif

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: waveform shapes, amplitude, config handshake/commit, reset.
// Build with DDS_SYNC_PULSE_EN defined to also exercise sync_out.

module tb_dds_wave_gen;

    localparam int PW = 32;
    localparam int DW = 8;
    localparam logic [PW-1:0] FW_DEF = 32'h0040_0000;
    localparam logic [PW-1:0] FW_2X  = 32'h0080_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          phase_clr = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [PW-1:0] cfg_fw = FW_DEF;
    logic [PW-1:0] cfg_poff = '0;
    logic [1:0]    cfg_wave = 2'd0;
    logic [7:0]    cfg_duty = 8'd128;
    logic [7:0]    cfg_amp = 8'd255;
    logic [DW-1:0] da_data;
    logic          da_valid;
`ifdef DDS_SYNC_PULSE_EN
    logic          sync_out;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dds_wave_gen #(.PHASE_W(PW), .DATA_W(DW), .RST_FW(FW_DEF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .phase_clr (phase_clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_fw    (cfg_fw),
        .cfg_poff  (cfg_poff),
        .cfg_wave  (cfg_wave),
        .cfg_duty  (cfg_duty),
        .cfg_amp   (cfg_amp),
        .da_data   (da_data),
        .da_valid  (da_valid)
`ifdef DDS_SYNC_PULSE_EN
       ,.sync_out  (sync_out)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Triangle code for sample index k at fw=2^22: up 0..255 then down 255..0, two cycles per code.
    function automatic int tri_exp(input int k);
        int m;
        m = k % 1024;
        if (m < 512)
            return m / 2;
        return 255 - ((m - 512) / 2);
    endfunction

    task automatic do_reset;
        rst_n = 1'b0; enable = 1'b0; phase_clr = 1'b0; cfg_valid = 1'b0;
        cfg_fw = FW_DEF; cfg_poff = '0; cfg_wave = 2'd0; cfg_duty = 8'd128; cfg_amp = 8'd255;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic cfg_send(input logic [PW-1:0] fw, input logic [PW-1:0] poff,
                            input logic [1:0] wave, input logic [7:0] duty, input logic [7:0] amp);
        bit done;
        done = 1'b0;
        cfg_fw = fw; cfg_poff = poff; cfg_wave = wave; cfg_duty = duty; cfg_amp = amp;
        cfg_valid = 1'b1;
        for (int i = 0; i < 3000 && !done; i++) begin
            done = cfg_ready;
            tick;
        end
        cfg_valid = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL cfg_send_timeout got=no_accept exp=accept");
        end
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #1;
        n_vec++; if (da_data !== 8'd0) begin n_err++; $display("FAIL rst_async_data got=%0d exp=0", da_data); end
        n_vec++; if (da_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got=%b exp=0", da_valid); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_async_ready got=%b exp=1", cfg_ready); end
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        n_vec++; if (da_data !== 8'd0) begin n_err++; $display("FAIL rst_rel_data got=%0d exp=0", da_data); end
        n_vec++; if (da_valid !== 1'b0) begin n_err++; $display("FAIL rst_rel_valid got=%b exp=0", da_valid); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_rel_ready got=%b exp=1", cfg_ready); end
`ifdef DDS_SYNC_PULSE_EN
        n_vec++; if (sync_out !== 1'b0) begin n_err++; $display("FAIL rst_sync got=%b exp=0", sync_out); end
`endif
    endtask

    task automatic test_triangle;
        do_reset;
        enable = 1'b1;
        for (int j = 1; j <= 1030; j++) begin
            tick;
            if (j <= 2) begin
                n_vec++;
                if (da_valid !== 1'b0) begin n_err++; $display("FAIL tri_valid_early j=%0d got=%b exp=0", j, da_valid); end
            end else begin
                n_vec++;
                if (da_valid !== 1'b1) begin n_err++; $display("FAIL tri_valid j=%0d got=%b exp=1", j, da_valid); end
            end
            if (j >= 2) begin
                n_vec++;
                if (da_data !== DW'(tri_exp(j - 2))) begin
                    n_err++; $display("FAIL tri_data j=%0d got=%0d exp=%0d", j, da_data, tri_exp(j - 2));
                end
            end
        end
    endtask

    task automatic test_square;
        int highs;
        int exp;
        do_reset;
        cfg_send(FW_DEF, '0, 2'd3, 8'd64, 8'd255);
        repeat (4) tick;
        phase_clr = 1'b1;
        tick;
        phase_clr = 1'b0;
        enable = 1'b1;
        highs = 0;
        for (int j = 1; j <= 1030; j++) begin
            tick;
            if (j >= 2) begin
                exp = (((j - 2) % 1024) < 256) ? 255 : 0;
                if (j <= 1025 && da_data == 8'd255) highs++;
                n_vec++;
                if (da_data !== DW'(exp)) begin n_err++; $display("FAIL sq_data j=%0d got=%0d exp=%0d", j, da_data, exp); end
            end
        end
        n_vec++;
        if (highs != 256) begin n_err++; $display("FAIL sq_high_count got=%0d exp=256", highs); end
        enable = 1'b0;
        cfg_send(FW_DEF, '0, 2'd3, 8'd0, 8'd255);
        repeat (4) tick;
        enable = 1'b1;
        for (int j = 1; j <= 1030; j++) begin
            tick;
            n_vec++;
            if (da_data !== 8'd0) begin n_err++; $display("FAIL sq_duty0 j=%0d got=%0d exp=0", j, da_data); end
        end
    endtask

    task automatic test_amplitude;
        int k;
        int raw;
        do_reset;
        cfg_send(FW_DEF, '0, 2'd1, 8'd128, 8'd127);
        repeat (4) tick;
        phase_clr = 1'b1;
        tick;
        phase_clr = 1'b0;
        enable = 1'b1;
        for (int j = 1; j <= 1030; j++) begin
            tick;
            if (j >= 2) begin
                k = (j - 2) % 1024;
                raw = k / 4;
                n_vec++;
                if (da_data !== DW'((raw * 128) >> 8)) begin
                    n_err++; $display("FAIL amp127 j=%0d got=%0d exp=%0d", j, da_data, (raw * 128) >> 8);
                end
                if (k == 1016) begin
                    n_vec++;
                    if (da_data !== 8'd127) begin n_err++; $display("FAIL amp127_raw254 got=%0d exp=127", da_data); end
                end
            end
        end
        enable = 1'b0;
        cfg_send(FW_DEF, '0, 2'd1, 8'd128, 8'd255);
        repeat (4) tick;
        phase_clr = 1'b1;
        tick;
        phase_clr = 1'b0;
        enable = 1'b1;
        for (int j = 1; j <= 1030; j++) begin
            tick;
            if (j >= 2) begin
                k = (j - 2) % 1024;
                n_vec++;
                if (da_data !== DW'(k / 4)) begin n_err++; $display("FAIL amp255 j=%0d got=%0d exp=%0d", j, da_data, k / 4); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int exp;
        do_reset;
        enable = 1'b1;
        for (int j = 1; j <= 2100; j++) begin
            tick;
            if (j == 300) begin
                cfg_fw = FW_2X; cfg_poff = '0; cfg_wave = 2'd0; cfg_duty = 8'd128; cfg_amp = 8'd255;
                cfg_valid = 1'b1;
            end
            if (j == 301) begin
                cfg_valid = 1'b0;
                n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_drop got=%b exp=0", cfg_ready); end
            end
            if (j == 1023) begin
                n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_pre_wrap got=%b exp=0", cfg_ready); end
                cfg_valid = 1'b1;
            end
            if (j == 1024) begin
                n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_commit got=%b exp=1", cfg_ready); end
            end
            if (j == 1025) begin
                n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL b2b_reaccept got=%b exp=0", cfg_ready); end
                cfg_valid = 1'b0;
            end
            if (j == 1535) begin
                n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_pre_wrap2 got=%b exp=0", cfg_ready); end
            end
            if (j == 1536) begin
                n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_commit2 got=%b exp=1", cfg_ready); end
            end
            if (j >= 3) begin
                exp = (j <= 1025) ? tri_exp(j - 2) : tri_exp(2 * (j - 1026));
                n_vec++;
                if (da_data !== DW'(exp)) begin n_err++; $display("FAIL b2b_data j=%0d got=%0d exp=%0d", j, da_data, exp); end
            end
        end
    endtask

    task automatic test_reset_pending;
        do_reset;
        enable = 1'b1;
        repeat (200) tick;
        cfg_fw = FW_2X; cfg_poff = '0; cfg_wave = 2'd0; cfg_duty = 8'd128; cfg_amp = 8'd255;
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rp_pending got=%b exp=0", cfg_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rp_ready got=%b exp=1", cfg_ready); end
        n_vec++; if (da_data !== 8'd0) begin n_err++; $display("FAIL rp_data got=%0d exp=0", da_data); end
        n_vec++; if (da_valid !== 1'b0) begin n_err++; $display("FAIL rp_valid got=%b exp=0", da_valid); end
        tick;
        rst_n = 1'b1;
        for (int j = 1; j <= 700; j++) begin
            tick;
            if (j >= 2) begin
                n_vec++;
                if (da_data !== DW'(tri_exp(j - 2))) begin
                    n_err++; $display("FAIL rp_fw_restored j=%0d got=%0d exp=%0d", j, da_data, tri_exp(j - 2));
                end
            end
        end
        cfg_fw = FW_DEF; cfg_poff = 32'h8000_0000; cfg_wave = 2'd1; cfg_duty = 8'd128; cfg_amp = 8'd255;
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL clr_pending got=%b exp=0", cfg_ready); end
        phase_clr = 1'b1;
        tick;
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL clr_commit got=%b exp=1", cfg_ready); end
        phase_clr = 1'b0;
        enable = 1'b0;
        tick;
        tick;
        n_vec++; if (da_data !== 8'd0) begin n_err++; $display("FAIL clr_old_cfg got=%0d exp=0", da_data); end
        tick;
        n_vec++; if (da_data !== 8'd128) begin n_err++; $display("FAIL clr_poff got=%0d exp=128", da_data); end
        n_vec++; if (da_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid_hold got=%b exp=0", da_valid); end
        repeat (5) tick;
        n_vec++; if (da_data !== 8'd128) begin n_err++; $display("FAIL clr_poff_hold got=%0d exp=128", da_data); end
    endtask

`ifdef DDS_SYNC_PULSE_EN
    task automatic test_sync;
        int pulses;
        bit exp;
        do_reset;
        enable = 1'b1;
        pulses = 0;
        for (int j = 1; j <= 2100; j++) begin
            tick;
            if (j >= 2) begin
                exp = (j == 1026) || (j == 2050);
                if (sync_out === 1'b1) pulses++;
                n_vec++;
                if (sync_out !== exp) begin n_err++; $display("FAIL sync_pos j=%0d got=%b exp=%b", j, sync_out, exp); end
                if (exp) begin
                    n_vec++;
                    if (da_data !== 8'd0) begin n_err++; $display("FAIL sync_code j=%0d got=%0d exp=0", j, da_data); end
                end
            end
        end
        n_vec++;
        if (pulses != 2) begin n_err++; $display("FAIL sync_count got=%0d exp=2", pulses); end
    endtask
`endif

    initial begin
        test_reset;
        test_triangle;
        test_square;
        test_amplitude;
        test_back_to_back;
        test_reset_pending;
`ifdef DDS_SYNC_PULSE_EN
        test_sync;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
